// File: rtl/voice_sched_pkg.sv
// Shared types and defaults for the voice step scheduler and its helpers.
package voice_sched_pkg;

  localparam int NUM_VOICES_DEF  = 4;
  localparam int ACK_TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    REQ  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational lowest-set-bit finder: returns the index of the lowest '1'
// in vec_i and flags whether any bit was set. Shared with the mixer arbiter.
module prio_enc_lsb #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    idx_o   = '0;
    valid_o = 1'b0;
    // Walk from the top down so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_step_sched.sv
// Sample-tick driven sequencer granting the shared voice-update datapath to each
// enabled voice in ascending order. Optional ack timeout: VOICE_STEP_SCHED_TIMEOUT_EN.
module voice_step_sched
  import voice_sched_pkg::*;
#(
  parameter int NUM_VOICES  = NUM_VOICES_DEF,
`ifdef VOICE_STEP_SCHED_TIMEOUT_EN
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
`endif
  localparam int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [NUM_VOICES-1:0] voice_en,
  input  logic                  tick,
  input  logic                  step_ack,
  output logic                  div_en,
  output logic                  step_req,
  output logic [IDX_W-1:0]      step_voice,
  output logic                  frame_done,
  output logic                  overrun,
`ifdef VOICE_STEP_SCHED_TIMEOUT_EN
  output logic                  timeout_err,
`endif
  input  logic                  overrun_clr
);

  sched_state_t          state_q;
  logic [NUM_VOICES-1:0] pend_q;
  logic                  div_en_q;
  logic                  step_req_q;
  logic [IDX_W-1:0]      step_voice_q;
  logic                  frame_done_q;
  logic                  overrun_q;

  logic [IDX_W-1:0]      next_idx;
  logic                  next_valid;
  logic                  step_done;

  prio_enc_lsb #(
    .WIDTH (NUM_VOICES),
    .IDX_W (IDX_W)
  ) u_prio (
    .vec_i   (pend_q),
    .idx_o   (next_idx),
    .valid_o (next_valid)
  );

`ifdef VOICE_STEP_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             timeout_err_q;
  logic             timeout_hit;

  // An ack in the final waiting cycle still counts as a normal completion.
  assign timeout_hit = (state_q == REQ) && !step_ack &&
                       (tmo_cnt_q == CNT_W'(ACK_TIMEOUT - 1));
  assign step_done   = step_ack || timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == REQ && !step_done) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
        tmo_cnt_q <= '0;
      end
      if (timeout_hit) begin
        timeout_err_q <= 1'b1;
      end else if (overrun_clr) begin
        timeout_err_q <= 1'b0;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign step_done = step_ack;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      div_en_q     <= 1'b0;
      step_req_q   <= 1'b0;
      step_voice_q <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      div_en_q     <= run;
      frame_done_q <= 1'b0;

      // A new overrun event beats a simultaneous clear.
      if (tick && state_q != IDLE) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (tick && run) begin
            pend_q  <= voice_en;
            state_q <= SCAN;
          end
        end

        SCAN: begin
          if (!run) begin
            pend_q  <= '0;
            state_q <= IDLE;
          end else if (!next_valid) begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            step_voice_q <= next_idx;
            step_req_q   <= 1'b1;
            state_q      <= REQ;
          end
        end

        REQ: begin
          if (step_done) begin
            step_req_q <= 1'b0;
            if (!run) begin
              // Abandon the rest of the frame silently.
              pend_q  <= '0;
              state_q <= IDLE;
            end else begin
              pend_q[step_voice_q] <= 1'b0;
              state_q              <= SCAN;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_en     = div_en_q;
  assign step_req   = step_req_q;
  assign step_voice = step_voice_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_voice_step_sched.sv
// Self-checking bench for voice_step_sched: directed scenarios plus randomized
// frames compared against an ordered-grant reference model.
module tb_voice_step_sched;

  localparam int NV    = 4;
  localparam int IDX_W = $clog2(NV);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run = 1'b0;
  logic [NV-1:0]    voice_en = '0;
  logic             tick = 1'b0;
  logic             step_ack = 1'b0;
  logic             overrun_clr = 1'b0;
  logic             div_en;
  logic             step_req;
  logic [IDX_W-1:0] step_voice;
  logic             frame_done;
  logic             overrun;
`ifdef VOICE_STEP_SCHED_TIMEOUT_EN
  logic             timeout_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  voice_step_sched #(
    .NUM_VOICES (NV)
`ifdef VOICE_STEP_SCHED_TIMEOUT_EN
    , .ACK_TIMEOUT (8)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .voice_en    (voice_en),
    .tick        (tick),
    .step_ack    (step_ack),
    .div_en      (div_en),
    .step_req    (step_req),
    .step_voice  (step_voice),
    .frame_done  (frame_done),
    .overrun     (overrun),
`ifdef VOICE_STEP_SCHED_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .overrun_clr (overrun_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    while (!step_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_seen"}, step_req, 1'b1);
  endtask

  // Reference model: a frame grants exactly the voices enabled at the tick, lowest
  // index first. Each grant costs one scan cycle plus the ack wait, and one final
  // scan finds nothing left, so the tick-sampling edge is followed by
  // sum(2 + delay) + 1 edges before frame_done appears (2N+1 with immediate acks).
  task automatic run_frame(input logic [NV-1:0] en, input logic [NV-1:0] en_mid,
                           input int min_d, input int max_d, input string tag);
    int exp_q[$];
    int n_exp, n_seen, tot_d, d, cyc, expv;
    bit done;
    for (int i = 0; i < NV; i++) if (en[i]) exp_q.push_back(i);
    n_exp  = exp_q.size();
    n_seen = 0;
    tot_d  = 0;
    cyc    = 0;
    done   = 1'b0;
    voice_en = en;
    tick     = 1'b1;
    @(negedge clk);
    cyc++;
    tick     = 1'b0;
    voice_en = en_mid;
    while (!done && cyc < 500) begin
      if (frame_done) begin
        done = 1'b1;
      end else if (step_req) begin
        expv = (exp_q.size() != 0) ? exp_q.pop_front() : 99;
        n_seen++;
        check({tag, "_voice"}, 32'(step_voice), 32'(expv));
        d = $urandom_range(max_d, min_d);
        tot_d += d;
        repeat (d) begin
          @(negedge clk);
          cyc++;
          check({tag, "_hold_req"}, step_req, 1'b1);
          check({tag, "_hold_voice"}, 32'(step_voice), 32'(expv));
        end
        step_ack = 1'b1;
        @(negedge clk);
        cyc++;
        step_ack = 1'b0;
        check({tag, "_req_drop"}, step_req, 1'b0);
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_grants"}, n_seen, n_exp);
    check({tag, "_latency"}, cyc, 2 * n_exp + tot_d + 2);
    @(negedge clk);
    check({tag, "_done_pulse"}, frame_done, 1'b0);
    check({tag, "_no_overrun"}, overrun, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_req, seen_done;
    int n;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_req", step_req, 1'b0);
    check("rst_voice", 32'(step_voice), 0);
    check("rst_done", frame_done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_div_en", div_en, 1'b0);
    rst = 1'b0;

    // div_en is run delayed by one clock.
    @(negedge clk);
    run = 1'b1;
    #1 check("div_en_lag", div_en, 1'b0);
    @(negedge clk);
    check("div_en_on", div_en, 1'b1);

    // Voices 0,1,3 with acks two cycles after each request.
    run_frame(4'b1011, 4'b1011, 2, 2, "f1011");

    // Empty frame: frame_done two cycles after the tick.
    run_frame(4'b0000, 4'b0000, 0, 0, "empty");

    // Mid-frame voice_en change has no effect.
    run_frame(4'b1111, 4'b0001, 0, 0, "midchg");

    // Tick while run is low is ignored.
    run = 1'b0;
    @(negedge clk);
    voice_en = 4'b1111;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    seen_req = 1'b0;
    seen_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen_req  |= step_req;
      seen_done |= frame_done;
    end
    check("norun_req", seen_req, 1'b0);
    check("norun_done", seen_done, 1'b0);
    check("norun_overrun", overrun, 1'b0);
    run = 1'b1;
    @(negedge clk);

    // Overrun: second tick while voice 0 waits for its ack.
    voice_en = 4'b0001;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_req("ovr", 10);
    check("ovr_before", overrun, 1'b0);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("ovr_set", overrun, 1'b1);
    repeat (3) @(negedge clk);
    check("ovr_sticky", overrun, 1'b1);
    tick = 1'b1;
    overrun_clr = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    overrun_clr = 1'b0;
    check("ovr_set_wins", overrun, 1'b1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_cleared", overrun, 1'b0);
    check("ovr_req_held", step_req, 1'b1);
    check("ovr_voice_held", 32'(step_voice), 0);
    step_ack = 1'b1;
    @(negedge clk);
    step_ack = 1'b0;
    n = 0;
    while (!frame_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ovr_frame_done", frame_done, 1'b1);
    check("ovr_still_clear", overrun, 1'b0);
    @(negedge clk);

    // Run drops while voice 2 is requested: finish handshake, no frame_done.
    voice_en = 4'b1111;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int v = 0; v < 2; v++) begin
      wait_req("drop", 10);
      check("drop_voice", 32'(step_voice), v);
      step_ack = 1'b1;
      @(negedge clk);
      step_ack = 1'b0;
    end
    wait_req("drop2", 10);
    check("drop_voice2", 32'(step_voice), 2);
    run = 1'b0;
    @(negedge clk);
    check("drop_div_en", div_en, 1'b0);
    check("drop_req_held", step_req, 1'b1);
    step_ack = 1'b1;
    @(negedge clk);
    step_ack = 1'b0;
    check("drop_req_off", step_req, 1'b0);
    seen_req = 1'b0;
    seen_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen_req  |= step_req;
      seen_done |= frame_done;
    end
    check("drop_no_req", seen_req, 1'b0);
    check("drop_no_done", seen_done, 1'b0);
    run = 1'b1;
    @(negedge clk);
    // Leftover voice 3 must not reappear.
    run_frame(4'b0001, 4'b0001, 0, 1, "after_drop");

`ifdef VOICE_STEP_SCHED_TIMEOUT_EN
    // Voice 1 is never acked: the request times out after 8 cycles.
    check("tmo_before", timeout_err, 1'b0);
    voice_en = 4'b0011;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_req("tmo0", 10);
    check("tmo_voice0", 32'(step_voice), 0);
    step_ack = 1'b1;
    @(negedge clk);
    step_ack = 1'b0;
    wait_req("tmo1", 10);
    check("tmo_voice1", 32'(step_voice), 1);
    n = 0;
    while (step_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("tmo_req_cycles", n, 8);
    check("tmo_err", timeout_err, 1'b1);
    n = 0;
    while (!frame_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("tmo_frame_done", frame_done, 1'b1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("tmo_err_clr", timeout_err, 1'b0);
`endif

    // Randomized frames with random mid-frame enable changes and ack delays.
    for (int k = 0; k < 25; k++) begin
      run_frame(NV'($urandom_range(0, 15)), NV'($urandom_range(0, 15)), 0, 3, "rnd");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_step_sched.md
Name: voice_step_sched

Overview:
- Sequencer between the sample-rate tick generator (the 8-bit divider that pulses its flag once every 256 enabled cycles) and the shared voice-update datapath.
- On each tick it snapshots the set of enabled voices and grants the datapath to each one in ascending index order, one step request at a time, using a req/ack handshake.
- Drives the divider's enable, flags frames that overrun the tick period, and reports frame completion to the mixer.

Parameters:
- NUM_VOICES, 4, number of voices sharing the datapath (2..16).
- IDX_W, $clog2(NUM_VOICES), width of the voice index (derived; not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- run  in  1  scheduler enable; also gates the divider
- voice_en  in  NUM_VOICES  per-voice enable, sampled only at tick
- tick  in  1  single-cycle sample tick from the divider flag
- step_ack  in  1  datapath finished the current voice step
- div_en  out  1  enable to the divider; equals registered run
- step_req  out  1  step request to the datapath
- step_voice  out  IDX_W  voice index for the current request
- frame_done  out  1  one-cycle pulse when all snapshotted voices are stepped
- overrun  out  1  sticky: a tick arrived while a frame was still in progress
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset: step_req=0, step_voice=0, frame_done=0, overrun=0, div_en=0; state IDLE; snapshot register=0.
- div_en is run registered once (1-cycle latency).
- State machine, states IDLE, SCAN, REQ:
  - IDLE: on tick && run, snapshot voice_en into pend[], go to SCAN. If tick arrives while run=0, ignore it.
  - SCAN: if pend==0, pulse frame_done next cycle and return to IDLE. Otherwise select the lowest set bit of pend, load step_voice, assert step_req, go to REQ. SCAN costs one cycle per granted voice.
  - REQ: hold step_req and step_voice stable until step_ack. On ack, sample at the clock edge, deassert step_req, clear that pend bit, go to SCAN.
- step_ack is ignored outside REQ. An ack in the same cycle step_req first rises is valid.
- A frame with all voices enabled and 0-cycle ack takes 2*NUM_VOICES+1 cycles from tick to frame_done.
- A tick while state != IDLE sets overrun. That tick is dropped, not queued, and the current frame continues.
- If overrun_clr and a new overrun event occur in the same cycle, set wins.
- If run drops mid-frame, finish the current REQ handshake, then go to IDLE with no frame_done. pend is cleared.
- Changes to voice_en mid-frame have no effect until the next tick.
- rst mid-handshake: step_req drops immediately (asynchronous) and the datapath must tolerate an abandoned request.

Optional Feature:
- Macro: VOICE_STEP_SCHED_TIMEOUT_EN.
- Defined: adds parameter ACK_TIMEOUT (default 64), a cycle counter in REQ, and output timeout_err (sticky, cleared by overrun_clr). If ACK_TIMEOUT cycles pass in REQ without step_ack:
  - deassert step_req;
  - clear that voice's pend bit;
  - set timeout_err;
  - continue SCAN.
- Undefined: REQ waits indefinitely, and no timeout_err port or counter exists.

Decomposition:
- Package voice_sched_pkg: enum sched_state_t {IDLE, SCAN, REQ}, default NUM_VOICES, ACK_TIMEOUT default.
- One sub-module, prio_enc_lsb: combinational lowest-set-bit finder over pend with a valid output. It is reused by the mixer arbiter.

Test Plan:
- NUM_VOICES=4, voice_en=4'b1011, tick, step_ack returned 2 cycles after each req -> step_voice sequence 0,1,3; frame_done pulses once; overrun=0.
- voice_en=0, tick -> no step_req; frame_done pulses 2 cycles after tick.
- Hold step_ack low; issue a second tick during REQ -> overrun=1 and stays set. Then assert overrun_clr -> overrun=0 next cycle; the original frame completes normally.
- voice_en=4'b1111 at tick, change it to 4'b0001 during the frame -> all four voices still stepped, in order 0..3.
- run dropped while in REQ for voice 2, then ack -> returns to IDLE, no frame_done, and div_en=0 one cycle after run falls.
- With VOICE_STEP_SCHED_TIMEOUT_EN and ACK_TIMEOUT=8, never ack voice 1 of 4'b0011 -> step_req drops after 8 cycles, timeout_err=1, frame_done still pulses.
